// File: rtl/pulse_swallow_counter_pkg.sv
// Shared constants, ratio type and clamp helpers for the P/S feedback divider.
// The S field of a ratio is never clamped; only P has a floor.
package pll_div_pkg;

  localparam int P_W   = 8;
  localparam int S_W   = 2;
  localparam int P_MIN = 3;
  localparam int P_RST = 16;
  localparam int S_RST = 0;

  localparam logic MC_DIV5 = 1'b0;
  localparam logic MC_DIV4 = 1'b1;

  typedef struct packed {
    logic [P_W-1:0] p;
    logic [S_W-1:0] s;
  } ratio_t;

  function automatic logic p_illegal(input logic [P_W-1:0] p);
    return p < P_W'(P_MIN);
  endfunction

  function automatic ratio_t clamp_ratio(input logic [P_W-1:0] p, input logic [S_W-1:0] s);
    ratio_t r;
    r.p = p_illegal(p) ? P_W'(P_MIN) : p;
    r.s = s;
    return r;
  endfunction

endpackage

// File: rtl/pulse_swallow_counter_if.sv
// Ratio request channel from the sigma-delta modulator to the divider.
interface pulse_swallow_counter_if
  import pll_div_pkg::*;
();

  logic [P_W-1:0] p_in;
  logic [S_W-1:0] s_in;
  logic           ratio_valid;
  logic           ratio_ready;

  modport master (
    output p_in,
    output s_in,
    output ratio_valid,
    input  ratio_ready
  );

  modport slave (
    input  p_in,
    input  s_in,
    input  ratio_valid,
    output ratio_ready
  );

endinterface

// File: rtl/pulse_swallow_counter_shadow.sv
// One-entry ratio shadow buffer: captures requests mid-cycle, hands a ratio to the
// counter on the drain strobe (shadow first, else a same-edge bypass), flags clamped P.
module ratio_shadow_buf
  import pll_div_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  ratio_t req_ratio_i,
  input  logic   req_valid_i,
  output logic   req_ready_o,
  input  logic   drain_i,
  output logic   load_en_o,
  output ratio_t load_ratio_o,
  output logic   err_o
);

  logic   full_q, full_d;
  ratio_t shadow_q, shadow_d;
  logic   err_q, err_d;
  logic   fire;
  ratio_t req_clamped;

  assign fire        = req_valid_i && !full_q;
  assign req_clamped = clamp_ratio(req_ratio_i.p, req_ratio_i.s);

  always_comb begin
    full_d       = full_q;
    shadow_d     = shadow_q;
    err_d        = err_q | (fire && p_illegal(req_ratio_i.p));
    load_en_o    = 1'b0;
    load_ratio_o = req_clamped;
    if (drain_i) begin
      // A full shadow blocks ready, so a drain and a fresh handshake never coincide.
      if (full_q) begin
        load_en_o    = 1'b1;
        load_ratio_o = shadow_q;
        full_d       = 1'b0;
      end else if (fire) begin
        load_en_o = 1'b1;
      end
    end else if (fire) begin
      shadow_d = req_clamped;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q   <= 1'b0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o = !full_q;
  assign err_o       = err_q;

endmodule

// File: rtl/pulse_swallow_counter.sv
// P/S pulse-swallow counter: N = 4P + S VCO cycles per div_out pulse, clocked by the
// 4/5 prescaler output and steering its modulus through a registered mc.
module pulse_swallow_counter
  import pll_div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  pulse_swallow_counter_if.slave  bus,
  output logic                    mc,
  output logic                    div_out,
  output logic                    ratio_err
);

  logic [P_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0] p_act_q, p_act_d;
  logic [S_W-1:0] s_act_q, s_act_d;
  logic           mc_q, mc_d;
  logic           div_q, div_d;
  logic           terminal;
  logic           load_en;
  ratio_t         load_ratio;
  ratio_t         req_ratio;

  assign req_ratio.p = bus.p_in;
  assign req_ratio.s = bus.s_in;

  ratio_shadow_buf u_shadow (
    .clk          (clk),
    .rst          (rst),
    .req_ratio_i  (req_ratio),
    .req_valid_i  (bus.ratio_valid),
    .req_ready_o  (bus.ratio_ready),
    .drain_i      (terminal),
    .load_en_o    (load_en),
    .load_ratio_o (load_ratio),
    .err_o        (ratio_err)
  );

  // p_act is clamped to at least P_MIN, so the subtraction never underflows.
  assign terminal = (cnt_q == (p_act_q - P_W'(1)));

  always_comb begin
    cnt_d   = terminal ? '0 : (cnt_q + P_W'(1));
    p_act_d = p_act_q;
    s_act_d = s_act_q;
    if (terminal && load_en) begin
      p_act_d = load_ratio.p;
      s_act_d = load_ratio.s;
    end
    // mc is evaluated on next-state values so it is already correct for the period it controls.
    mc_d  = (cnt_d < {{(P_W-S_W){1'b0}}, s_act_d}) ? MC_DIV5 : MC_DIV4;
    div_d = terminal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      p_act_q <= P_W'(P_RST);
      s_act_q <= S_W'(S_RST);
      mc_q    <= (S_RST > 0) ? MC_DIV5 : MC_DIV4;
      div_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      p_act_q <= p_act_d;
      s_act_q <= s_act_d;
      mc_q    <= mc_d;
      div_q   <= div_d;
    end
  end

  assign mc      = mc_q;
  assign div_out = div_q;

endmodule

// File: tb/tb_pulse_swallow_counter.sv
// Directed scenarios plus random ratio traffic against a queue-based divider model.
module tb_pulse_swallow_counter;
  import pll_div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mc, div_out, ratio_err;

  always #5 clk = ~clk;

  pulse_swallow_counter_if bus ();

  pulse_swallow_counter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mc        (mc),
    .div_out   (div_out),
    .ratio_err (ratio_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: active ratio, position inside the current division cycle, pending ratios.
  int m_p, m_s, m_pos;
  bit m_div, m_err;
  int q_p[$];
  int q_s[$];
  // VCO-period accounting over each completed division cycle.
  int vco_acc, cyc_p, cyc_s;
  bit acc_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    chk("mc", mc, (m_pos < m_s) ? 0 : 1);
    chk("div_out", div_out, m_div);
    chk("ratio_ready", bus.ratio_ready, (q_p.size() == 0) ? 1 : 0);
    chk("ratio_err", ratio_err, m_err);
    if (m_pos == 0) begin
      if (acc_valid) chk("vco_per_pulse", vco_acc, 4 * cyc_p + cyc_s);
      vco_acc   = 0;
      acc_valid = 1'b1;
      cyc_p     = m_p;
      cyc_s     = m_s;
    end
    vco_acc += (mc === 1'b1) ? 4 : 5;
  endtask

  task automatic step(input bit v, input int p, input int s, output bit acc);
    bit accepted;
    int rp;
    bus.ratio_valid = v;
    bus.p_in        = 8'(p);
    bus.s_in        = 2'(s);
    sample();
    @(posedge clk);
    accepted = v && (q_p.size() == 0);
    rp = (p < 3) ? 3 : p;
    if (accepted && p < 3) m_err = 1'b1;
    if (m_pos == m_p - 1) begin
      m_pos = 0;
      m_div = 1'b1;
      if (q_p.size() > 0) begin
        m_p = q_p.pop_front();
        m_s = q_s.pop_front();
      end else if (accepted) begin
        m_p = rp;
        m_s = s;
      end
    end else begin
      m_pos++;
      m_div = 1'b0;
      if (accepted) begin
        q_p.push_back(rp);
        q_s.push_back(s);
      end
    end
    acc = accepted;
    @(negedge clk);
    bus.ratio_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, acc);
  endtask

  task automatic send(input int p, input int s);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 100) begin
      step(1'b1, p, s, acc);
      guard++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    $display("ratio write P=%0d S=%0d accepted after %0d clk", p, s, guard);
  endtask

  // Called at a negedge; asserts reset and checks outputs react without a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_mc", mc, 1);
    chk("rst_div_out", div_out, 0);
    chk("rst_ready", bus.ratio_ready, 1);
    chk("rst_err", ratio_err, 0);
    m_p = 16; m_s = 0; m_pos = 0; m_div = 1'b0; m_err = 1'b0;
    q_p.delete(); q_s.delete();
    acc_valid = 1'b0; vco_acc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_for(input int p_want, input int pos_want);
    int guard = 0;
    bit acc;
    while (!(m_p == p_want && m_pos == pos_want) && guard < 200) begin
      step(1'b0, 0, 0, acc);
      guard++;
    end
    if (guard >= 200) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    bit acc;
    bus.ratio_valid = 1'b0;
    bus.p_in = '0;
    bus.s_in = '0;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    $display("step: reset defaults");
    idle(40);

    $display("step: P=10 S=3 mid-cycle");
    wait_for(16, 4);
    send(10, 3);
    idle(40);

    $display("step: back-to-back (10,3) then (12,1)");
    wait_for(10, 2);
    send(10, 3);
    send(12, 1);
    idle(40);

    $display("step: bypass (20,2) on terminal edge");
    wait_for(12, 11);
    chk("bypass_shadow_empty", bus.ratio_ready, 1);
    step(1'b1, 20, 2, acc);
    chk("bypass_accepted", acc, 1);
    chk("bypass_ready_stays", bus.ratio_ready, 1);
    idle(45);

    $display("step: illegal P=1 S=2");
    send(1, 2);
    idle(15);
    send(9, 1);
    idle(25);
    chk("err_sticky", ratio_err, 1);

    $display("step: reset mid-cycle with shadow full");
    send(10, 3);
    wait_for(10, 1);
    send(10, 3);
    while (m_pos != 5) step(1'b0, 0, 0, acc);
    chk("pre_rst_shadow_full", bus.ratio_ready, 0);
    do_reset();
    idle(40);

    $display("step: random ratio traffic");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 24), $urandom_range(0, 3), acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
